// File: rtl/npc_btb.sv
// npc_btb: fetch PC register plus a direct-mapped BTB with 2-bit saturating counters.
// Latency: lookup and flush are combinational; the PC and BTB update on the next edge. A mispredict redirect overrides stall.
// Optional perf counters are built only when NPC_BTB_PERF_EN is defined.
module npc_btb #(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    output logic [XLEN-1:0] pc_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            ex_valid,
    input  logic            ex_is_ctrl,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            flush_o,
    output logic [31:0]     perf_ctrl_o,
    output logic [31:0]     perf_mispred_o
);
    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q  [BTB_ENTRIES];
    logic            valid_d  [BTB_ENTRIES];
    logic [TAGW-1:0] tag_q    [BTB_ENTRIES];
    logic [TAGW-1:0] tag_d    [BTB_ENTRIES];
    logic [XLEN-1:0] target_q [BTB_ENTRIES];
    logic [XLEN-1:0] target_d [BTB_ENTRIES];
    logic [1:0]      ctr_q    [BTB_ENTRIES];
    logic [1:0]      ctr_d    [BTB_ENTRIES];

    logic [IDX-1:0]  f_idx, e_idx;
    logic [TAGW-1:0] f_tag, e_tag;
    logic            f_hit, e_hit;
    logic [XLEN-1:0] pc_plus4, ex_pc_plus4, ex_target_al, redirect;
    logic            mispredict;

    // Fetch-side lookup on the registered PC.
    assign f_idx         = pc_q[IDX+1:2];
    assign f_tag         = pc_q[XLEN-1:IDX+2];
    assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pc_plus4      = pc_q + XLEN'(4);
    assign pred_taken_o  = f_hit && ctr_q[f_idx][1];
    assign pred_target_o = f_hit ? target_q[f_idx] : pc_plus4;
    assign pc_o          = pc_q;

    assign e_idx        = ex_pc[IDX+1:2];
    assign e_tag        = ex_pc[XLEN-1:IDX+2];
    assign e_hit        = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign ex_pc_plus4  = ex_pc + XLEN'(4);
    assign ex_target_al = {ex_target[XLEN-1:1], 1'b0};

    // The raw target is compared, so an odd JALR target always forces a redirect.
    assign mispredict = ex_valid &&
                        ((ex_is_ctrl && (ex_taken != ex_pred_taken)) ||
                         (ex_is_ctrl && ex_taken && (ex_target != ex_pred_target)) ||
                         (!ex_is_ctrl && ex_pred_taken));
    assign flush_o    = mispredict;
    assign redirect   = (ex_is_ctrl && ex_taken) ? ex_target_al : ex_pc_plus4;

    always_comb begin
        pc_d = pc_plus4;
        if (mispredict) begin
            pc_d = redirect;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken_o) begin
            pc_d = pred_target_o;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (ex_valid && ex_is_ctrl) begin
            if (e_hit) begin
                if (ex_taken) begin
                    if (ctr_q[e_idx] != 2'b11) begin
                        ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
                    end
                    target_d[e_idx] = ex_target_al;
                end else if (ctr_q[e_idx] != 2'b00) begin
                    ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
                end
            end else if (ex_taken) begin
                valid_d[e_idx]  = 1'b1;
                tag_d[e_idx]    = e_tag;
                target_d[e_idx] = ex_target_al;
                ctr_d[e_idx]    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // Payload fields are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        ctr_q    <= ctr_d;
    end

`ifdef NPC_BTB_PERF_EN
    logic [31:0] perf_ctrl_q, perf_ctrl_d;
    logic [31:0] perf_mispred_q, perf_mispred_d;

    always_comb begin
        perf_ctrl_d    = perf_ctrl_q;
        perf_mispred_d = perf_mispred_q;
        if (ex_valid && ex_is_ctrl) begin
            perf_ctrl_d = perf_ctrl_q + 32'd1;
        end
        if (mispredict) begin
            perf_mispred_d = perf_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_ctrl_q    <= '0;
            perf_mispred_q <= '0;
        end else begin
            perf_ctrl_q    <= perf_ctrl_d;
            perf_mispred_q <= perf_mispred_d;
        end
    end

    assign perf_ctrl_o    = perf_ctrl_q;
    assign perf_mispred_o = perf_mispred_q;
`else
    assign perf_ctrl_o    = '0;
    assign perf_mispred_o = '0;
`endif

endmodule
